// File: rtl/ifm_pingpong_ctrl.sv
// Ping-pong sequencer for the two-bank IFM memory: fills one bank from the previous layer,
// drains the other as A/B read pairs for the next layer, and swaps banks via ifm_sel.
module ifm_pingpong_ctrl #(
  parameter int IFM_SIZE         = 14,
  parameter int ADDRESS_SIZE_IFM = $clog2(IFM_SIZE*IFM_SIZE)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic                        rd_start,
  output logic                        rd_ready,
  output logic                        rd_done,
  output logic                        ifm_sel,
  output logic                        ifm_enable_write_previous,
  output logic [ADDRESS_SIZE_IFM-1:0] ifm_address_write_previous,
  output logic                        ifm_enable_read_A_next,
  output logic                        ifm_enable_read_B_next,
  output logic [ADDRESS_SIZE_IFM-1:0] ifm_address_read_A_next,
  output logic [ADDRESS_SIZE_IFM-1:0] ifm_address_read_B_next
);

  localparam int N      = IFM_SIZE*IFM_SIZE;
  localparam int NPAIRS = (N + 1) / 2;
  localparam bit ODD    = (N % 2) == 1;
  localparam logic [ADDRESS_SIZE_IFM-1:0] LAST_WR   = ADDRESS_SIZE_IFM'(N - 1);
  localparam logic [ADDRESS_SIZE_IFM-1:0] LAST_PAIR = ADDRESS_SIZE_IFM'(NPAIRS - 1);

  logic [ADDRESS_SIZE_IFM-1:0] wr_cnt;
  logic [ADDRESS_SIZE_IFM-1:0] rd_cnt;
  logic                        wr_full;
  logic                        rd_full;
  logic                        rd_active;

  logic [ADDRESS_SIZE_IFM-1:0] nxt_k;
  logic [ADDRESS_SIZE_IFM-1:0] nxt_a;
  logic [ADDRESS_SIZE_IFM-1:0] nxt_b;
  logic                        nxt_b_en;
  logic                        swap;

  assign wr_ready                   = !wr_full;
  assign ifm_enable_write_previous  = wr_valid & wr_ready;
  assign ifm_address_write_previous = wr_cnt;
  assign rd_ready                   = rd_full & !rd_active;
  assign swap                       = wr_full & !rd_full & !rd_active;

  // Next read pair to present; an odd-sized bank has no B word in its final pair.
  always_comb begin
    nxt_k    = rd_active ? rd_cnt + 1'b1 : '0;
    nxt_a    = nxt_k << 1;
    nxt_b_en = !(ODD && (nxt_k == LAST_PAIR));
    nxt_b    = nxt_b_en ? nxt_a + 1'b1 : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ifm_sel                 <= 1'b0;
      wr_cnt                  <= '0;
      wr_full                 <= 1'b0;
      rd_full                 <= 1'b0;
      rd_active               <= 1'b0;
      rd_cnt                  <= '0;
      rd_done                 <= 1'b0;
      ifm_enable_read_A_next  <= 1'b0;
      ifm_enable_read_B_next  <= 1'b0;
      ifm_address_read_A_next <= '0;
      ifm_address_read_B_next <= '0;
    end else begin
      if (ifm_enable_write_previous) begin
        if (wr_cnt == LAST_WR) begin
          wr_full <= 1'b1;
          wr_cnt  <= '0;
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
        end
      end

      if (swap) begin
        ifm_sel <= ~ifm_sel;
        wr_full <= 1'b0;
        rd_full <= 1'b1;
      end

      // Drain: rd_cnt is the index of the pair currently on the read ports.
      if (rd_active) begin
        if (rd_cnt == LAST_PAIR) begin
          rd_active               <= 1'b0;
          rd_full                 <= 1'b0;
          rd_done                 <= 1'b0;
          ifm_enable_read_A_next  <= 1'b0;
          ifm_enable_read_B_next  <= 1'b0;
          ifm_address_read_A_next <= '0;
          ifm_address_read_B_next <= '0;
        end else begin
          rd_cnt                  <= nxt_k;
          rd_done                 <= (nxt_k == LAST_PAIR);
          ifm_enable_read_A_next  <= 1'b1;
          ifm_enable_read_B_next  <= nxt_b_en;
          ifm_address_read_A_next <= nxt_a;
          ifm_address_read_B_next <= nxt_b;
        end
      end else if (rd_start && rd_ready) begin
        rd_active               <= 1'b1;
        rd_cnt                  <= '0;
        rd_done                 <= (LAST_PAIR == '0);
        ifm_enable_read_A_next  <= 1'b1;
        ifm_enable_read_B_next  <= nxt_b_en;
        ifm_address_read_A_next <= nxt_a;
        ifm_address_read_B_next <= nxt_b;
      end
    end
  end

endmodule
